// File: rtl/div_if.sv
// Start/busy/done handshake and operand/result bundle between the
// pipeline (master) and the sequenced divider (slave).
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signdiv;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;

    modport master (
        output start, signdiv, a, b,
        input  busy, done, q, r, div_by_zero
    );

    modport slave (
        input  start, signdiv, a, b,
        output busy, done, q, r, div_by_zero
    );
endinterface

// File: rtl/div_sequencer.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per clock,
// with a sign-magnitude prologue (PREP) and a sign/zero fix-up epilogue (FIX).
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  reset,
    div_if.slave  bus
);
    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_C = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE_C  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic             load_s, prep_s, iter_s, fix_s;
    logic [WIDTH-1:0] a_r, b_r;
    logic             sd_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    logic [WIDTH-1:0] rem_r;
    logic             neg_q_r, neg_r_r, dbz_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] q_r, r_r;
    logic             dbz_out_r, busy_r, done_r;
    logic [WIDTH:0]   rem_sh_s, diff_s;
    logic             ge_s;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        cond_neg = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_s = PREP;
                else           state_s = IDLE;
            end
            PREP: state_s = ITER;
            ITER: begin
                if (cnt_r == LAST_C) state_s = FIX;
                else                 state_s = ITER;
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        load_s = 1'b0;
        prep_s = 1'b0;
        iter_s = 1'b0;
        fix_s  = 1'b0;
        case (state_r)
            IDLE:    load_s = bus.start;
            PREP:    prep_s = 1'b1;
            ITER:    iter_s = 1'b1;
            FIX:     fix_s  = 1'b1;
            default: load_s = 1'b0;
        endcase
    end

    // WIDTH+1-bit trial subtract; the borrow out decides the quotient bit
    always_comb begin
        rem_sh_s = {rem_r, dvd_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, dsr_r};
        ge_s     = ~diff_s[WIDTH];
    end

    // Datapath and registered outputs; dvd_r shifts the dividend out and the quotient in
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            sd_r      <= 1'b0;
            dvd_r     <= {WIDTH{1'b0}};
            dsr_r     <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            dbz_r     <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            q_r       <= {WIDTH{1'b0}};
            r_r       <= {WIDTH{1'b0}};
            dbz_out_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= fix_s;
            if (load_s) begin
                a_r    <= bus.a;
                b_r    <= bus.b;
                sd_r   <= bus.signdiv;
                busy_r <= 1'b1;
            end
            if (prep_s) begin
                dvd_r   <= cond_neg(sd_r & a_r[WIDTH-1], a_r);
                dsr_r   <= cond_neg(sd_r & b_r[WIDTH-1], b_r);
                neg_q_r <= sd_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                neg_r_r <= sd_r & a_r[WIDTH-1];
                dbz_r   <= (b_r == {WIDTH{1'b0}});
                rem_r   <= {WIDTH{1'b0}};
                cnt_r   <= {CW{1'b0}};
            end
            if (iter_s) begin
                rem_r <= ge_s ? diff_s[WIDTH-1:0] : rem_sh_s[WIDTH-1:0];
                dvd_r <= {dvd_r[WIDTH-2:0], ge_s};
                cnt_r <= cnt_r + ONE_C;
            end
            if (fix_s) begin
                busy_r    <= 1'b0;
                dbz_out_r <= dbz_r;
                if (dbz_r) begin
                    q_r <= {WIDTH{1'b1}};
                    r_r <= a_r;
                end else begin
                    q_r <= cond_neg(neg_q_r, dvd_r);
                    r_r <= cond_neg(neg_r_r, rem_r);
                end
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.q           = q_r;
    assign bus.r           = r_r;
    assign bus.div_by_zero = dbz_out_r;
endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed bench for div_sequencer against an arithmetic
// reference model of DIV/DIVU semantics.
module tb_div_sequencer;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    div_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] eq, output logic [31:0] er, output logic ez);
        int sa;
        int sb;
        sa = av;
        sb = bv;
        ez = 1'b0;
        if (bv == 32'd0) begin
            eq = 32'hFFFF_FFFF;
            er = av;
            ez = 1'b1;
        end else if (sd && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            eq = 32'h8000_0000;
            er = 32'd0;
        end else if (sd) begin
            eq = sa / sb;
            er = sa % sb;
        end else begin
            eq = av / bv;
            er = av % bv;
        end
    endfunction

    // Issues one division from between clock edges and waits (bounded) for done.
    // glitch >= 0 pulses start with junk operands after that many cycles.
    task automatic run_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                           input int glitch, output int lat, output int busy_n,
                           output logic [31:0] qo, output logic [31:0] ro, output logic dz);
        bus.start   = 1'b1;
        bus.signdiv = sd;
        bus.a       = av;
        bus.b       = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_n    = bus.busy ? 1 : 0;
        while (lat < 100) begin
            if (lat == glitch) begin
                bus.start   = 1'b1;
                bus.signdiv = ~sd;
                bus.a       = $urandom;
                bus.b       = $urandom;
            end
            @(posedge clk);
            #1;
            lat++;
            bus.start = 1'b0;
            if (bus.done) break;
            if (bus.busy) busy_n++;
        end
        qo = bus.q;
        ro = bus.r;
        dz = bus.div_by_zero;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.signdiv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0;
        reset     = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.q !== 32'd0) begin n_err++; $display("FAIL reset_q got=%h exp=0", bus.q); end
        n_cmp++; if (bus.r !== 32'd0) begin n_err++; $display("FAIL reset_r got=%h exp=0", bus.r); end
        n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    endtask

    task automatic test_directed();
        logic        t_sd [9];
        logic [31:0] t_a  [9];
        logic [31:0] t_b  [9];
        logic [31:0] t_q  [9];
        logic [31:0] t_r  [9];
        logic        t_z  [9];
        int lat, bn;
        logic [31:0] qo, ro;
        logic dz;
        t_sd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        t_a  = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'd9, 32'hFFFF_FF9C};
        t_b  = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd3, 32'hFFFF_FFF9};
        t_q  = '{32'h0000_000E, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd14};
        t_r  = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 32'd5, 32'd5, 32'd0, 32'hFFFF_FFFE};
        t_z  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            run_div(t_sd[i], t_a[i], t_b[i], -1, lat, bn, qo, ro, dz);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            n_cmp++; if (bn !== LAT) begin n_err++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bn, LAT); end
            n_cmp++; if (qo !== t_q[i]) begin n_err++; $display("FAIL dir%0d_q got=%h exp=%h", i, qo, t_q[i]); end
            n_cmp++; if (ro !== t_r[i]) begin n_err++; $display("FAIL dir%0d_r got=%h exp=%h", i, ro, t_r[i]); end
            n_cmp++; if (dz !== t_z[i]) begin n_err++; $display("FAIL dir%0d_dbz got=%b exp=%b", i, dz, t_z[i]); end
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, bus.busy); end
            @(posedge clk);
            #1;
            n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, bus.done); end
            n_cmp++; if (bus.q !== t_q[i] || bus.r !== t_r[i]) begin n_err++; $display("FAIL dir%0d_hold got=%h/%h exp=%h/%h", i, bus.q, bus.r, t_q[i], t_r[i]); end
        end
    endtask

    task automatic test_random();
        int lat, bn;
        logic [31:0] av, bv, qo, ro, eq, er;
        logic sd, dz, ez;
        int g;
        for (int i = 0; i < 40; i++) begin
            sd = 1'($urandom_range(0, 1));
            av = $urandom;
            case ($urandom_range(0, 3))
                0:       bv = 32'($urandom_range(0, 20));
                1:       bv = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                2:       bv = $urandom >> $urandom_range(0, 31);
                default: bv = $urandom;
            endcase
            g = (i % 3 == 0) ? $urandom_range(1, 30) : -1;
            model(sd, av, bv, eq, er, ez);
            @(negedge clk);
            run_div(sd, av, bv, g, lat, bn, qo, ro, dz);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            n_cmp++; if (qo !== eq || ro !== er || dz !== ez) begin
                n_err++;
                $display("FAIL rnd%0d_result sd=%b a=%h b=%h got q=%h r=%h z=%b exp q=%h r=%h z=%b",
                         i, sd, av, bv, qo, ro, dz, eq, er, ez);
            end
            @(posedge clk);
            #1;
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rnd%0d_idle_after got=%b exp=0", i, bus.busy); end
        end
    endtask

    task automatic test_abort();
        int seen_done;
        int lat, bn;
        logic [31:0] qo, ro;
        logic dz;
        seen_done = 0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.signdiv = 1'b0;
        bus.a       = 32'd100;
        bus.b       = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 10) begin
                bus.start = 1'b1;
                bus.a     = 32'd50;
                bus.b     = 32'd5;
            end
            if (c == 20) reset = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) seen_done++;
        end
        reset = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.q !== 32'd0 || bus.r !== 32'd0) begin n_err++; $display("FAIL abort_qr got=%h/%h exp=0/0", bus.q, bus.r); end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen_done++;
        end
        n_cmp++; if (seen_done !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", seen_done); end
        @(negedge clk);
        run_div(1'b0, 32'd50, 32'd5, -1, lat, bn, qo, ro, dz);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL abort_fresh_latency got=%0d exp=%0d", lat, LAT); end
        n_cmp++; if (qo !== 32'd10 || ro !== 32'd0 || dz !== 1'b0) begin n_err++; $display("FAIL abort_fresh_result got=%h/%h/%b exp=a/0/0", qo, ro, dz); end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        logic [31:0] qo, ro, eq, er;
        logic dz, ez;
        logic [31:0] av, bv;
        logic sd;
        @(negedge clk);
        run_div(1'b1, 32'hFFFF_FF00, 32'd3, -1, lat, bn, qo, ro, dz);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, LAT); end
        for (int i = 0; i < 4; i++) begin
            sd = 1'($urandom_range(0, 1));
            av = $urandom;
            bv = $urandom >> $urandom_range(0, 31);
            model(sd, av, bv, eq, er, ez);
            run_div(sd, av, bv, -1, lat, bn, qo, ro, dz);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, lat, LAT); end
            n_cmp++; if (qo !== eq || ro !== er || dz !== ez) begin
                n_err++;
                $display("FAIL b2b%0d_result got q=%h r=%h z=%b exp q=%h r=%h z=%b", i, qo, ro, dz, eq, er, ez);
            end
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.signdiv = 1'b0;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multicycle controller and datapath for the CPU's DIV/DIVU instructions. It replaces the combinational divider with a sequenced restoring radix-2 divider and a start/busy/done handshake. It sits beside the ALU. The HI/LO write logic takes q/r on done, and the hazard unit stalls MFHI/MFLO while busy is high.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a division; accepted only when busy=0
signdiv  input  1  1=signed (DIV), 0=unsigned (DIVU); sampled with start
a  input  WIDTH  dividend; sampled with start
b  input  WIDTH  divisor; sampled with start
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse; q/r/div_by_zero valid from this cycle
q  output  WIDTH  quotient (to LO)
r  output  WIDTH  remainder (to HI)
div_by_zero  output  1  set with done when b=0; held until the next done

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, q=0, r=0, div_by_zero=0, internal registers cleared. A reset mid-operation aborts the division immediately; no done is produced.
- States: IDLE, PREP, ITER, FIX.
- IDLE: on start=1, latch a, b and signdiv, then go to PREP. start is ignored while busy=1. start is accepted in the same cycle that done is high (back-to-back).
- PREP (1 cycle): form magnitudes. In signed mode a negative operand is two's-complement negated; in unsigned mode operands pass through. Record neg_q = signdiv & (a[MSB]^b[MSB]), neg_r = signdiv & a[MSB], and dbz = (b==0). Clear the partial remainder and iteration counter, then go to ITER.
- ITER (WIDTH cycles, one quotient bit per cycle, MSB first):
  - shift the partial remainder left, bringing in the next dividend bit;
  - if partial remainder >= divisor magnitude, subtract the divisor and set the quotient bit to 1, else set it to 0;
  - use a WIDTH+1-bit compare/subtract so no carry is lost;
  - after the WIDTH-th iteration go to FIX.
- FIX (1 cycle):
  - q = neg_q ? -quotient : quotient;
  - r = neg_r ? -remainder : remainder;
  - if dbz, force q=all-ones, r=latched a (raw), div_by_zero=1; otherwise div_by_zero=0;
  - outputs are registered on the FIX->IDLE edge, with done=1 and busy=0 in that same cycle.
- Latency: with the start edge counted as E0, done is high in the cycle following edge E(WIDTH+2), which is 34 clocks for WIDTH=32. Latency is fixed and independent of operands, including b=0.
- busy is high for exactly WIDTH+2 cycles per division.
- q, r and div_by_zero hold their values between done pulses. Changes on a/b/signdiv while busy have no effect.
- Signed overflow: -2^(WIDTH-1) / -1 gives q=-2^(WIDTH-1) (wraps) and r=0, with no flag.
- Remainder sign follows the dividend. The quotient truncates toward zero.

Test Plan:
- Unsigned 100/7 (signdiv=0): start at E0 -> busy for 34 cycles, done 1 cycle, q=0x0000000E, r=0x00000002, div_by_zero=0.
- Signed -7/2 (a=0xFFFFFFF9, b=2): q=0xFFFFFFFD, r=0xFFFFFFFF. Also 7/-2 -> q=0xFFFFFFFD, r=0x00000001.
- a=0x80000000, b=0xFFFFFFFF: signed -> q=0x80000000, r=0; unsigned -> q=0, r=0x80000000.
- Divide by zero, a=5, b=0, both modes: done after 34 cycles, q=0xFFFFFFFF, r=0x00000005, div_by_zero=1. A following 9/3 clears the flag and gives q=3, r=0.
- Start 100/7, pulse start with 50/5 at cycle 10 (ignored), assert reset at cycle 20: busy=0 the next cycle, no done, q=r=0. A fresh 50/5 then gives q=10, r=0 after 34 cycles.
- Back-to-back: assert start with new operands in the done cycle -> accepted; the second done arrives exactly 34 cycles later with correct results.
